// File: rtl/adder_pipe_param.sv
// adder_pipe_param
//   Pipelined add/subtract unit. WIDTH-bit operands are split into STAGES
//   equal chunks. Each pipeline stage adds one chunk, and the carry is
//   registered between stages, so the critical path is a single
//   WIDTH/STAGES-bit add. A valid/ready handshake is used on both sides.
//
//   Optional feature macro: ADDER_SAT_EN
//     When defined, the last stage applies signed saturation to S on overflow.
//     When undefined, S is the wrapped result modulo 2^WIDTH.
//
// Parameters
//   WIDTH   operand/result width; must be a multiple of STAGES and >= 2
//   STAGES  pipeline depth, which is also the number of carry chunks
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      A/B/Cin/Sub valid this cycle
//   in_ready   out  1      unit accepts input this cycle
//   A, B       in   WIDTH  operands (two's complement for Ovout)
//   Cin        in   1      carry-in (Sub=0) / borrow-in (Sub=1)
//   Sub        in   1      0: S=A+B+Cin, 1: S=A-B-Cin
//   out_valid  out  1      S/Cout/Ovout valid
//   out_ready  in   1      downstream accepts result
//   S          out  WIDTH  result
//   Cout       out  1      carry out of MSB (subtract: 1 = no borrow)
//   Ovout      out  1      signed overflow of the unsaturated result
module adder_pipe_param #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovout
);

  localparam int CH = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

`ifdef ADDER_SAT_EN
  function automatic logic signed [WIDTH-1:0] saturate(
    input logic signed [WIDTH-1:0] s,
    input logic                    ovf,
    input logic                    neg
  );
    if (!ovf) return s;
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  // Stage registers: index k holds the state after stage k has added chunk k.
  logic                    vld_p [STAGES];
  logic signed [WIDTH-1:0] a_p   [STAGES];
  logic signed [WIDTH-1:0] bx_p  [STAGES];
  logic signed [WIDTH-1:0] sum_p [STAGES];
  logic                    cy_p  [STAGES];
  logic                    ovf_p;

  // Stage inputs (_d) and stage results (_n).
  logic signed [WIDTH-1:0] a_d   [STAGES];
  logic signed [WIDTH-1:0] bx_d  [STAGES];
  logic signed [WIDTH-1:0] sum_d [STAGES];
  logic                    c_d   [STAGES];
  logic signed [WIDTH-1:0] sum_n [STAGES];
  logic                    c_n   [STAGES];
  logic [CH:0]             chunk;
  logic                    msb_cin;
  logic                    ovf_n;

  // The whole pipeline advances together, so a stall never collapses bubbles.
  assign in_ready  = !vld_p[L] || out_ready;
  assign out_valid = vld_p[L];
  assign S         = sum_p[L];
  assign Cout      = cy_p[L];
  assign Ovout     = ovf_p;

  always_comb begin
    // Subtraction is A + ~B + !Cin, so B is inverted once at the entry point.
    a_d[0]   = A;
    bx_d[0]  = Sub ? ~B : B;
    c_d[0]   = Sub ? ~Cin : Cin;
    sum_d[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      a_d[k]   = a_p[k-1];
      bx_d[k]  = bx_p[k-1];
      c_d[k]   = cy_p[k-1];
      sum_d[k] = sum_p[k-1];
    end

    chunk = '0;
    for (int k = 0; k < STAGES; k++) begin
      chunk = {1'b0, a_d[k][k*CH +: CH]} + {1'b0, bx_d[k][k*CH +: CH]}
            + {{CH{1'b0}}, c_d[k]};
      sum_n[k]              = sum_d[k];
      sum_n[k][k*CH +: CH]  = chunk[CH-1:0];
      c_n[k]                = chunk[CH];
    end

    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    msb_cin = a_d[L][WIDTH-1] ^ bx_d[L][WIDTH-1] ^ sum_n[L][WIDTH-1];
    ovf_n   = msb_cin ^ c_n[L];
`ifdef ADDER_SAT_EN
    sum_n[L] = saturate(sum_n[L], ovf_n, a_d[L][WIDTH-1]);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= 1'b0;
        a_p[k]   <= '0;
        bx_p[k]  <= '0;
        sum_p[k] <= '0;
        cy_p[k]  <= 1'b0;
      end
      ovf_p <= 1'b0;
    end else if (in_ready) begin
      vld_p[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        a_p[k]   <= a_d[k];
        bx_p[k]  <= bx_d[k];
        sum_p[k] <= sum_n[k];
        cy_p[k]  <= c_n[k];
      end
      ovf_p <= ovf_n;
    end
  end

endmodule

// File: tb/tb_adder_pipe_param.sv
// tb_adder_pipe_param
//   Directed bench for adder_pipe_param at WIDTH=16, STAGES=4.
//   Define ADDER_SAT_EN for both files to exercise the saturating build.
module tb_adder_pipe_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic        Sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] S;
  logic        Cout;
  logic        Ovout;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ADDER_SAT_EN
  localparam logic [15:0] EXP_OVF_POS = 16'h7FFF;
  localparam logic [15:0] EXP_OVF_NEG = 16'h8000;
  localparam logic [15:0] EXP_V7      = 16'h7FFF;
`else
  localparam logic [15:0] EXP_OVF_POS = 16'h8000;
  localparam logic [15:0] EXP_OVF_NEG = 16'h7FFF;
  localparam logic [15:0] EXP_V7      = 16'h8001;
`endif

  adder_pipe_param #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Sub       (Sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout),
    .Ovout     (Ovout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input logic [15:0] es,
                         input logic ec, input logic eo);
    int lat;
    @(negedge clk);
    A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1; out_ready = 1'b1;
    check({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "_lat"}, lat, 32'd4);
    check({tag, "_s"}, {16'b0, S}, {16'b0, es});
    check({tag, "_cout"}, {31'b0, Cout}, {31'b0, ec});
    check({tag, "_ovf"}, {31'b0, Ovout}, {31'b0, eo});
    @(posedge clk);
    #1;
  endtask

  // Stream vectors with hand-computed results.
  logic [15:0] va  [8] = '{16'h0001, 16'h1234, 16'hFFFF, 16'h00FF, 16'h5000, 16'h1000, 16'h0010, 16'h7000};
  logic [15:0] vb  [8] = '{16'h0001, 16'h4321, 16'h0001, 16'h0F01, 16'h1000, 16'h2000, 16'h0001, 16'h1000};
  logic        vc  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        vs  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [15:0] es  [8] = '{16'h0002, 16'h5555, 16'h0000, 16'h1000, 16'h4000, 16'hF000, 16'h000E, EXP_V7};
  logic        ecy [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  logic        prod_r;
  logic [15:0] held_s;
  logic        held_c;
  int          got;
  int          cyc;
  int          stale;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_vld",  {31'b0, out_valid}, 32'd0);
    check("rst_s",    {16'b0, S}, 32'd0);
    check("rst_cout", {31'b0, Cout}, 32'd0);
    check("rst_ovf",  {31'b0, Ovout}, 32'd0);
    check("rst_rdy",  {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_one("add_basic", 16'h0004, 16'h0008, 1'b1, 1'b0, 16'h000D, 1'b0, 1'b0);
    run_one("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, EXP_OVF_POS, 1'b0, 1'b1);
    run_one("sub_neg",   16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    run_one("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, EXP_OVF_NEG, 1'b1, 1'b1);

    // Back-to-back stream with a 3-cycle output stall.
    got = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          A = va[i]; B = vb[i]; Cin = vc[i]; Sub = vs[i]; in_valid = 1'b1;
          do begin
            @(negedge clk);
            prod_r = in_ready;
            @(posedge clk);
            #1;
          end while (!prod_r);
        end
        in_valid = 1'b0;
      end
      begin
        cyc = 0;
        while (got < 8 && cyc < 80) begin
          @(negedge clk);
          cyc++;
          if (out_valid && out_ready) begin
            check($sformatf("strm_s%0d", got), {16'b0, S}, {16'b0, es[got]});
            check($sformatf("strm_c%0d", got), {31'b0, Cout}, {31'b0, ecy[got]});
            got++;
          end
        end
        check("strm_count", got, 32'd8);
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        held_s = S;
        held_c = Cout;
        check("stall_vld0", {31'b0, out_valid}, 32'd1);
        check("stall_rdy0", {31'b0, in_ready}, 32'd0);
        for (int j = 1; j < 3; j++) begin
          @(negedge clk);
          check($sformatf("stall_rdy%0d", j), {31'b0, in_ready}, 32'd0);
          check($sformatf("stall_s%0d", j), {16'b0, S}, {16'b0, held_s});
          check($sformatf("stall_c%0d", j), {31'b0, Cout}, {31'b0, held_c});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Two vectors in flight, held at the output, then an asynchronous reset.
    out_ready = 1'b0;
    A = 16'h0100; B = 16'h0200; Cin = 1'b0; Sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 A = 16'h0011; B = 16'h0022;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("mid_pre_vld", {31'b0, out_valid}, 32'd1);
    check("mid_pre_s",   {16'b0, S}, 32'h0300);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", {31'b0, out_valid}, 32'd0);
    check("mid_rst_s",   {16'b0, S}, 32'd0);
    check("mid_rst_rdy", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale", stale, 32'd0);
    run_one("post_rst", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
